// File: rtl/encap_packet.sv
// Transmit-side DFX packetizer: slices one 1034-bit word into 19 Aurora frames
// (55-bit payload + 9-bit header) and drives them with a valid/ready handshake.
module encap_packet #(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int PAYLOAD_WIDTH     = 55,
  parameter int NUM_FRAMES        = 19
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_DFX_WIDTH-1:0]    data_dfx_in,
  input  logic                         valid_dfx_in,
  output logic                         ready_dfx_in,
  output logic [AURORA_DATA_WIDTH-1:0] tx_tdata,
  output logic                         tx_tvalid,
  input  logic                         tx_tready,
  output logic                         tx_tlast,
  output logic                         busy,
  output logic                         done_encap_pkt
);

  localparam logic [4:0] LAST_FRAME = 5'(NUM_FRAMES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                         state_q, state_d;
  logic [4:0]                     frame_cnt_q, frame_cnt_d;
  logic [DATA_DFX_WIDTH-1:0]      shadow_q, shadow_d;
  logic [AURORA_DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                           tvalid_q, tvalid_d;
  logic                           done_q, done_d;
  logic [DATA_DFX_WIDTH-1:0]      frame_word;
  logic [4:0]                     frame_idx;
  logic [AURORA_DATA_WIDTH-1:0]   frame_next;

  // The final frame shifts past the top of the word, so its upper 11 payload
  // bits fall out as zeros without a special case.
  function automatic logic [AURORA_DATA_WIDTH-1:0] build_frame(
    input logic [DATA_DFX_WIDTH-1:0] word,
    input logic [4:0]                k
  );
    logic [DATA_DFX_WIDTH-1:0] shifted;
    shifted = word >> (int'(k) * PAYLOAD_WIDTH);
    return {shifted[PAYLOAD_WIDTH-1:0], k == 5'd0, k == LAST_FRAME, k, 2'b00};
  endfunction

  // One shared slicer: frame 0 comes straight from the input word, later
  // frames from the shadow copy.
  assign frame_word = (state_q == IDLE) ? data_dfx_in : shadow_q;
  assign frame_idx  = (state_q == IDLE) ? 5'd0 : frame_cnt_q + 5'd1;
  assign frame_next = build_frame(frame_word, frame_idx);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    shadow_d    = shadow_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_dfx_in) begin
          shadow_d    = data_dfx_in;
          frame_cnt_d = 5'd0;
          tdata_d     = frame_next;
          tvalid_d    = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (tvalid_q && tx_tready) begin
          if (frame_cnt_q == LAST_FRAME) begin
            tvalid_d = 1'b0;
            tdata_d  = '0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            frame_cnt_d = frame_cnt_q + 5'd1;
            tdata_d     = frame_next;
          end
        end
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order. The shadow word is reset
  // too, so a reset leaves no trace of an abandoned packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      shadow_q    <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      shadow_q    <= shadow_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      done_q      <= done_d;
    end
  end

  assign ready_dfx_in   = (state_q == IDLE);
  assign busy           = (state_q == SEND);
  assign tx_tdata       = tdata_q;
  assign tx_tvalid      = tvalid_q;
  assign tx_tlast       = tvalid_q && (frame_cnt_q == LAST_FRAME);
  assign done_encap_pkt = done_q;

endmodule

// File: tb/tb_encap_packet.sv
// Self-checking bench for encap_packet: fixed-pattern frame table, random
// loopback through a bit-level decapsulation model, and corner sequences.
module tb_encap_packet;

  localparam int W   = 1034;
  localparam int NFR = 19;
  localparam int PL  = 55;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  data_dfx_in;
  logic          valid_dfx_in;
  logic          ready_dfx_in;
  logic [63:0]   tx_tdata;
  logic          tx_tvalid;
  logic          tx_tready;
  logic          tx_tlast;
  logic          busy;
  logic          done_encap_pkt;

  int errors = 0;
  int checks = 0;

  encap_packet dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_dfx_in    (data_dfx_in),
    .valid_dfx_in   (valid_dfx_in),
    .ready_dfx_in   (ready_dfx_in),
    .tx_tdata       (tx_tdata),
    .tx_tvalid      (tx_tvalid),
    .tx_tready      (tx_tready),
    .tx_tlast       (tx_tlast),
    .busy           (busy),
    .done_encap_pkt (done_encap_pkt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [63:0] exp_tdata;
    logic        exp_tlast;
  } vec_t;

  vec_t vecs[NFR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample and drive 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: bit-by-bit slicing of the word by global bit index.
  function automatic logic [63:0] model_frame(input logic [W-1:0] w, input int k);
    logic [63:0] f;
    f = '0;
    for (int b = 0; b < PL; b++)
      if (k * PL + b < W) f[9 + b] = w[k * PL + b];
    f[8]   = (k == 0);
    f[7]   = (k == NFR - 1);
    f[6:2] = 5'(k);
    return f;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[i] = 1'($urandom_range(1));
    return w;
  endfunction

  task automatic send_word(input logic [W-1:0] w);
    int n;
    n = 0;
    while (!ready_dfx_in && n < 100) begin
      step();
      n++;
    end
    check("ready_wait_timeout", 64'(n < 100), 64'd1);
    data_dfx_in  = w;
    valid_dfx_in = 1'b1;
    step();
    valid_dfx_in = 1'b0;
  endtask

  // Frame 0 must already be visible; checks all frames at full rate.
  task automatic drain_packet(input logic [W-1:0] w, input string name);
    for (int k = 0; k < NFR; k++) begin
      check({name, "_tvalid"}, 64'(tx_tvalid), 64'd1);
      check({name, "_tdata"}, tx_tdata, model_frame(w, k));
      check({name, "_tlast"}, 64'(tx_tlast), 64'(k == NFR - 1));
      step();
    end
    check({name, "_done"}, 64'(done_encap_pkt), 64'd1);
  endtask

  task automatic run_random(input logic [W-1:0] w);
    logic [W-1:0] rebuilt;
    int k, cyc, idx;
    rebuilt = '0;
    k = 0;
    cyc = 0;
    send_word(w);
    while (k < NFR && cyc < 400) begin
      check("rand_tdata", tx_tdata, model_frame(w, k));
      check("rand_tlast", 64'(tx_tlast), 64'(k == NFR - 1));
      tx_tready = ($urandom_range(3) != 0);
      if (tx_tready && tx_tvalid) begin
        // far-end decapsulation: place payload bits using the header index
        for (int b = 0; b < PL; b++) begin
          idx = int'(tx_tdata[6:2]) * PL + b;
          if (idx < W) rebuilt[idx] = tx_tdata[9 + b];
        end
        k++;
      end
      step();
      cyc++;
    end
    tx_tready = 1'b1;
    check("rand_timeout", 64'(cyc < 400), 64'd1);
    check("rand_done", 64'(done_encap_pkt), 64'd1);
    check("loopback_bit_errors", 64'($countones(rebuilt ^ w)), 64'd0);
  endtask

  logic [W-1:0] alt_word, w1, w2;
  int exp_k;

  initial begin
    rst_n        = 1'b0;
    valid_dfx_in = 1'b0;
    data_dfx_in  = '0;
    tx_tready    = 1'b1;
    for (int i = 0; i < W; i++) alt_word[i] = i[0];
    for (int k = 0; k < NFR; k++) begin
      vecs[k].k = k;
      if (k == NFR - 1)
        vecs[k].exp_tdata[63:9] = 55'h0AAAAAAAAAAA;
      else if (k % 2 == 0)
        vecs[k].exp_tdata[63:9] = 55'h2AAAAAAAAAAAAA;
      else
        vecs[k].exp_tdata[63:9] = 55'h55555555555555;
      vecs[k].exp_tdata[8:0] = {k == 0, k == NFR - 1, 5'(k), 2'b00};
      vecs[k].exp_tlast      = (k == NFR - 1);
    end

    // Reset state
    #2;
    check("rst_ready", 64'(ready_dfx_in), 64'd1);
    check("rst_tvalid", 64'(tx_tvalid), 64'd0);
    check("rst_tdata", tx_tdata, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done_encap_pkt), 64'd0);
    check("rst_tlast", 64'(tx_tlast), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Alternating-bit word against the constant table
    send_word(alt_word);
    check("alt_busy", 64'(busy), 64'd1);
    check("alt_ready", 64'(ready_dfx_in), 64'd0);
    for (int i = 0; i < NFR; i++) begin
      check("alt_tvalid", 64'(tx_tvalid), 64'd1);
      check($sformatf("alt_frame%0d", vecs[i].k), tx_tdata, vecs[i].exp_tdata);
      check("alt_tlast", 64'(tx_tlast), 64'(vecs[i].exp_tlast));
      check("alt_done_low", 64'(done_encap_pkt), 64'd0);
      step();
    end
    check("alt_done", 64'(done_encap_pkt), 64'd1);
    check("alt_done_ready", 64'(ready_dfx_in), 64'd1);
    check("alt_end_tvalid", 64'(tx_tvalid), 64'd0);
    check("alt_end_tdata", tx_tdata, 64'd0);
    step();
    check("alt_done_pulse", 64'(done_encap_pkt), 64'd0);

    // Backpressure on frame 5: tready 0,0 then 1 while frame 5 is shown
    w1 = rand_word();
    send_word(w1);
    for (int c = 0; c < 21; c++) begin
      exp_k = (c < 5) ? c : (c <= 7) ? 5 : c - 2;
      check("bp_tvalid", 64'(tx_tvalid), 64'd1);
      check($sformatf("bp_cycle%0d", c), tx_tdata, model_frame(w1, exp_k));
      if (c >= 5 && c <= 7) check("bp_hdr", 64'(tx_tdata[8:0]), 64'h014);
      tx_tready = !(c == 5 || c == 6);
      step();
    end
    tx_tready = 1'b1;
    check("bp_done", 64'(done_encap_pkt), 64'd1);
    step();

    // valid held with changing data during SEND
    w1 = rand_word();
    data_dfx_in  = w1;
    valid_dfx_in = 1'b1;
    step();
    for (int k = 0; k < NFR; k++) begin
      data_dfx_in  = rand_word();
      valid_dfx_in = (k < NFR - 1);
      check("hold_ready", 64'(ready_dfx_in), 64'd0);
      check("hold_tdata", tx_tdata, model_frame(w1, k));
      step();
    end
    valid_dfx_in = 1'b0;
    check("hold_done", 64'(done_encap_pkt), 64'd1);
    step();
    check("hold_no_reaccept", 64'(tx_tvalid), 64'd0);

    // Back-to-back words: second accepted 20 cycles after the first
    w1 = rand_word();
    w2 = rand_word();
    data_dfx_in  = w1;
    valid_dfx_in = 1'b1;
    step();
    data_dfx_in = w2;
    for (int k = 0; k < NFR; k++) begin
      check("b2b_w1", tx_tdata, model_frame(w1, k));
      step();
    end
    check("b2b_idle_tvalid", 64'(tx_tvalid), 64'd0);
    check("b2b_idle_ready", 64'(ready_dfx_in), 64'd1);
    check("b2b_idle_done", 64'(done_encap_pkt), 64'd1);
    step();
    valid_dfx_in = 1'b0;
    drain_packet(w2, "b2b_w2");
    step();

    // Reset asserted while frame 9 is on the link
    w1 = rand_word();
    send_word(w1);
    for (int k = 0; k < 9; k++) step();
    check("rst9_hdr", 64'(tx_tdata[8:0]), 64'h024);
    rst_n = 1'b0;
    #1;
    check("rst9_tvalid", 64'(tx_tvalid), 64'd0);
    check("rst9_tdata", tx_tdata, 64'd0);
    check("rst9_busy", 64'(busy), 64'd0);
    check("rst9_ready", 64'(ready_dfx_in), 64'd1);
    check("rst9_tlast", 64'(tx_tlast), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst9_idle_tvalid", 64'(tx_tvalid), 64'd0);
    w2 = rand_word();
    send_word(w2);
    check("rst9_sof", 64'(tx_tdata[8]), 64'd1);
    drain_packet(w2, "rst9_restart");
    step();

    // Random loopback with random backpressure
    for (int p = 0; p < 100; p++) run_random(rand_word());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/encap_packet.md
# encap_packet

Transmit-side packetizer for the inter-board DFX link. It accepts one 1034-bit DFX word (1024-bit data plus 10-bit address) from the input-port logic and slices it into 19 64-bit Aurora frames: a 55-bit payload in bits [63:9] and a 9-bit header in bits [8:0]. It drives the Aurora TX user interface with a valid/ready handshake. Its frame layout is the exact inverse of the receive-side decapsulator, so the far-end decapsulator rebuilds the original word bit-for-bit.

## Interface
- DATA_WIDTH, 1024, data field width
- ADDR_WIDTH, 10, address field width
- DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH (1034), packed word width; address occupies the top ADDR_WIDTH bits
- AURORA_DATA_WIDTH, 64, link frame width
- PAYLOAD_WIDTH, 55, payload bits per frame
- NUM_FRAMES, 19, frames per packet (ceil(1034/55))

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- data_dfx_in  in  DATA_DFX_WIDTH  word to send
- valid_dfx_in  in  1  data_dfx_in valid
- ready_dfx_in  out  1  block can accept a word
- tx_tdata  out  AURORA_DATA_WIDTH  frame to Aurora TX
- tx_tvalid  out  1  tx_tdata valid
- tx_tready  in  1  Aurora accepts frame
- tx_tlast  out  1  current frame is frame 18
- busy  out  1  packet in flight
- done_encap_pkt  out  1  one-cycle pulse after the last frame is accepted

## Operation
- Two states: IDLE and SEND. Reset state is IDLE.
- ready_dfx_in = (state==IDLE). It is combinational and therefore reads 1 during and after reset.
- IDLE: when valid_dfx_in is 1, data_dfx_in is captured into a shadow register on the clock edge. frame_cnt (5 bits) is set to 0, tx_tdata is loaded with frame 0, tx_tvalid goes to 1, and the state moves to SEND.
- Frame k, for k = 0..17:
  - tx_tdata[63:9] = word[k*55 +: 55]
- Frame 18:
  - tx_tdata[63:53] = 11'b0
  - tx_tdata[52:9] = word[1033:990], which is 44 bits
- Header, all frames:
  - [8] SOF = (k==0)
  - [7] EOF = (k==18)
  - [6:2] = k
  - [1:0] = 2'b00
- SEND: on each edge where tx_tvalid and tx_tready are both 1:
  - if frame_cnt < 18: frame_cnt increments and tx_tdata is reloaded with the next frame.
  - if frame_cnt == 18: tx_tvalid goes to 0, tx_tdata clears to 0, done_encap_pkt goes to 1 for one cycle, and the state returns to IDLE.
- Backpressure: when tx_tvalid=1 and tx_tready=0, tx_tdata, tx_tlast and frame_cnt hold unchanged. tx_tvalid is never dropped before the frame is accepted.
- valid_dfx_in is ignored in SEND. The shadow register does not change mid-packet.
- tx_tlast = tx_tvalid & (frame_cnt==18).
- busy = (state==SEND).
- Reset asserted mid-packet: the packet is abandoned immediately. All outputs take their reset values and the block restarts in IDLE with no partial frames.
- Reset values:
  - tx_tdata = 0
  - tx_tvalid = 0
  - tx_tlast = 0
  - busy = 0
  - done_encap_pkt = 0
  - frame_cnt = 0
  - shadow register = 0

## Timing
- Acceptance edge to first frame: frame 0 is on tx_tdata with tx_tvalid=1 in the cycle immediately after the accept edge.
- With tx_tready held at 1, frames 0..18 occupy 19 consecutive cycles.
- done_encap_pkt is 1 in the cycle after the frame-18 handshake. ready_dfx_in is 1 in that same cycle.
- Minimum spacing between accepted words is 20 cycles: 19 frames plus 1 IDLE accept cycle.
- All outputs except ready_dfx_in, tx_tlast and busy are registered. Those three are decoded directly from registered state.

## Test plan
- Single packet, tx_tready=1, data_dfx_in with bit i = i[0] (alternating):
  - frames 0..18 appear on 19 consecutive cycles.
  - frame 0 = {55-bit 0x2AAAAAAAAAAAAA, 9'h100}.
  - frame 18 has [63:53]=0 and header 9'h0C8.
  - done_encap_pkt pulses once.
- Loopback into the receive decapsulator with random words: the reconstructed 1034-bit word equals the input for 100 packets.
- Backpressure with tx_tready = 1,0,0,1 pattern on frame 5:
  - tx_tdata and header 9'h014 hold for 3 cycles.
  - total packet length is 21 cycles.
  - no frame is skipped or repeated.
- valid_dfx_in held at 1 with a changing data_dfx_in during SEND: ready_dfx_in=0, and the transmitted frames match only the word captured first.
- Two words presented back-to-back with tx_tready=1: the second is accepted exactly 20 cycles after the first, and its frame 0 follows the first word's frame 18 after one idle cycle.
- rst_n pulsed low at frame 9: tx_tvalid drops asynchronously, and after release the next word is transmitted from frame 0 with SOF set.
